// File: rtl/div_ctrl_pkg.sv
// Shared opcode encodings, bus widths and opcode helpers for the divide sequencer.
// Optional build macro: DIV_ZERO_BYPASS_EN (see div_ctrl).
package div_ctrl_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OP_W       = 3;

    localparam logic [OP_W-1:0] INST_DIV  = 3'b100;
    localparam logic [OP_W-1:0] INST_DIVU = 3'b101;
    localparam logic [OP_W-1:0] INST_REM  = 3'b110;
    localparam logic [OP_W-1:0] INST_REMU = 3'b111;

    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic is_rem_op(input logic [OP_W-1:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Combinational detector for divide-by-zero and signed overflow, with the
// architecturally defined result for each case.
module div_special_case
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DW = REG_W
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [DW-1:0]   dividend_i,
    input  logic [DW-1:0]   divisor_i,
    output logic            special_c,
    output logic [DW-1:0]   result_c
);

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    logic div_zero_c;
    logic ovf_c;

    assign div_zero_c = (divisor_i == '0);
    assign ovf_c      = is_signed_op(op_i) && (dividend_i == MIN_NEG) && (divisor_i == '1);
    assign special_c  = div_zero_c | ovf_c;

    always_comb begin
        result_c = '0;
        if (div_zero_c) begin
            result_c = is_rem_op(op_i) ? dividend_i : '1;
        end else if (ovf_c) begin
            result_c = is_rem_op(op_i) ? '0 : MIN_NEG;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between execute and the multi-cycle divider: capture, run, write back.
// Define DIV_ZERO_BYPASS_EN to resolve zero-divisor / overflow cases without the divider.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DW          = REG_W,
    parameter int unsigned AW          = REG_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [DW-1:0]   dividend_i,
    input  logic [DW-1:0]   divisor_i,
    input  logic [AW-1:0]   rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            div_start_o,
    output logic [DW-1:0]   div_dividend_o,
    output logic [DW-1:0]   div_divisor_o,
    output logic [OP_W-1:0] div_op_o,
    output logic [AW-1:0]   div_reg_waddr_o,
    input  logic            div_ready_i,
    input  logic [DW-1:0]   div_result_i,
    output logic            we_o,
    output logic [AW-1:0]   waddr_o,
    output logic [DW-1:0]   wdata_o,
    output logic            timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_d, we_d, timeout_d;
    logic [DW-1:0]    dividend_d, divisor_d, wdata_d;
    logic [OP_W-1:0]  op_d;
    logic [AW-1:0]    rd_d, waddr_d;

    logic             accept_c;
    logic             bypass_c;
    logic [DW-1:0]    bypass_result_c;

    assign accept_c = req_i & ~flush_i;

`ifdef DIV_ZERO_BYPASS_EN
    div_special_case #(.DW(DW)) u_special_case (
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .special_c  (bypass_c),
        .result_c   (bypass_result_c)
    );
`else
    assign bypass_c        = 1'b0;
    assign bypass_result_c = '0;
`endif

    // Stall is the only combinational output; gated by reset so it is 0 while held.
    assign stall_o = rst & (((state_q == ST_IDLE) & accept_c) | (state_q == ST_RUN));

    // Next state and next values of every registered output
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d    = div_start_o;
        we_d       = 1'b0;
        timeout_d  = timeout_o;
        dividend_d = div_dividend_o;
        divisor_d  = div_divisor_o;
        op_d       = div_op_o;
        rd_d       = div_reg_waddr_o;
        waddr_d    = waddr_o;
        wdata_d    = wdata_o;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    dividend_d = dividend_i;
                    divisor_d  = divisor_i;
                    op_d       = op_i;
                    rd_d       = rd_i;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    if (bypass_c) begin
                        state_d = ST_WB;
                        we_d    = 1'b1;
                        waddr_d = rd_i;
                        wdata_d = bypass_result_c;
                    end else begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Flush beats a same-cycle ready; ready beats the last watchdog cycle.
                if (flush_i) begin
                    state_d = ST_IDLE;
                    start_d = 1'b0;
                end else if (div_ready_i) begin
                    state_d = ST_WB;
                    start_d = 1'b0;
                    we_d    = 1'b1;
                    waddr_d = div_reg_waddr_o;
                    wdata_d = div_result_i;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYC)) begin
                    state_d   = ST_IDLE;
                    start_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            div_start_o     <= 1'b0;
            we_o            <= 1'b0;
            timeout_o       <= 1'b0;
            div_dividend_o  <= '0;
            div_divisor_o   <= '0;
            div_op_o        <= '0;
            div_reg_waddr_o <= '0;
            waddr_o         <= '0;
            wdata_o         <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            div_start_o     <= start_d;
            we_o            <= we_d;
            timeout_o       <= timeout_d;
            div_dividend_o  <= dividend_d;
            div_divisor_o   <= divisor_d;
            div_op_o        <= op_d;
            div_reg_waddr_o <= rd_d;
            waddr_o         <= waddr_d;
            wdata_o         <= wdata_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, corner sequences and random ops
// against a behavioural divide model; builds with or without DIV_ZERO_BYPASS_EN.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i, divisor_i;
    logic [4:0]  rd_i;
    logic        stall_o, div_start_o;
    logic [31:0] div_dividend_o, div_divisor_o;
    logic [2:0]  div_op_o;
    logic [4:0]  div_reg_waddr_o;
    logic        div_ready_i;
    logic [31:0] div_result_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        timeout_o;

    div_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_i           (req_i),
        .op_i            (op_i),
        .dividend_i      (dividend_i),
        .divisor_i       (divisor_i),
        .rd_i            (rd_i),
        .flush_i         (flush_i),
        .stall_o         (stall_o),
        .div_start_o     (div_start_o),
        .div_dividend_o  (div_dividend_o),
        .div_divisor_o   (div_divisor_o),
        .div_op_o        (div_op_o),
        .div_reg_waddr_o (div_reg_waddr_o),
        .div_ready_i     (div_ready_i),
        .div_result_i    (div_result_i),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .wdata_o         (wdata_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int div_lat = 1;
    int run_cnt = 0;
    bit hold_ready = 0;
    bit spurious_rdy = 0;
    bit in_wb = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    // RISC-V M-extension divide/remainder semantics
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return (op == INST_REM || op == INST_REMU) ? a : 32'hFFFF_FFFF;
        if ((op == INST_DIV || op == INST_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (op == INST_REM) ? 32'h0 : 32'h8000_0000;
        case (op)
            INST_DIV:  return 32'(sa / sb);
            INST_DIVU: return a / b;
            INST_REM:  return 32'(sa % sb);
            default:   return a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One clock; afterwards the divider model reacts to the sampled start
    task automatic tick();
        @(posedge clk);
        #1;
        if (div_start_o && !hold_ready) begin
            run_cnt++;
            div_ready_i  = (run_cnt >= div_lat);
            div_result_i = div_ready_i ? ref_div(div_op_o, div_dividend_o, div_divisor_o)
                                       : 32'hDEAD_BEEF;
        end else begin
            if (!div_start_o) run_cnt = 0;
            div_ready_i  = spurious_rdy;
            div_result_i = 32'hDEAD_BEEF;
        end
    endtask

    task automatic idle(input int k);
        req_i   = 1'b0;
        flush_i = 1'b0;
        if (in_wb) begin
            tick();
            chk("we_one_cycle", 32'(we_o), 32'd0);
            in_wb = 0;
        end
        repeat (k) tick();
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int lat,
                         input logic [31:0] exp);
        bit byp;
        bit seen;
        int n;
        int starts;
        byp = 0;
`ifdef DIV_ZERO_BYPASS_EN
        byp = (b == 32'h0) || ((op == INST_DIV || op == INST_REM) &&
                               a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`endif
        div_lat    = lat;
        req_i      = 1'b1;
        flush_i    = 1'b0;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_i       = rd;
        #1;
        if (in_wb) begin
            chk({tag, "_stall_in_wb"}, 32'(stall_o), 32'd0);
            tick();
            chk({tag, "_we_one_cycle"}, 32'(we_o), 32'd0);
            in_wb = 0;
        end
        chk({tag, "_stall_req"}, 32'(stall_o), 32'd1);
        seen   = 0;
        starts = 0;
        for (n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) chk({tag, "_timeout_clr"}, 32'(timeout_o), 32'd0);
            if (div_start_o) begin
                starts++;
                if (starts == 1) begin
                    chk({tag, "_op_a"}, div_dividend_o, a);
                    chk({tag, "_op_b"}, div_divisor_o, b);
                    chk({tag, "_op"}, 32'(div_op_o), 32'(op));
                    chk({tag, "_stall_run"}, 32'(stall_o), 32'd1);
                end
            end
            if (we_o) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_we_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), byp ? 32'd1 : 32'(lat + 1));
        chk({tag, "_start_cycles"}, 32'(starts), byp ? 32'd0 : 32'(lat));
        chk({tag, "_waddr"}, 32'(waddr_o), 32'(rd));
        chk({tag, "_wdata"}, wdata_o, exp);
        chk({tag, "_stall_wb"}, 32'(stall_o), 32'd0);
        chk({tag, "_no_timeout"}, 32'(timeout_o), 32'd0);
        req_i = 1'b0;
        in_wb = 1;
    endtask

    task automatic flush_run(input string tag, input int lat, input int after);
        int starts;
        div_lat    = lat;
        req_i      = 1'b1;
        op_i       = INST_DIVU;
        dividend_i = 32'd1000;
        divisor_i  = 32'd7;
        rd_i       = 5'd5;
        starts     = 0;
        for (int n = 0; n < 60 && starts < after; n++) begin
            tick();
            if (div_start_o) starts++;
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        req_i   = 1'b0;
        #1;
        chk({tag, "_start_drop"}, 32'(div_start_o), 32'd0);
        chk({tag, "_no_we"}, 32'(we_o), 32'd0);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        repeat (3) begin
            tick();
            chk({tag, "_no_we_later"}, 32'(we_o), 32'd0);
        end
    endtask

    initial begin
        int starts;
        bit we_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{INST_DIV,  32'd15,          32'd3,          5'd12, 3,  32'd5};
        vecs[1]  = '{INST_REMU, 32'hFFFF_FFFF,   32'h10,         5'd7,  2,  32'hF};
        vecs[2]  = '{INST_DIVU, 32'd100,         32'd7,          5'd3,  1,  32'd14};
        vecs[3]  = '{INST_DIV,  32'd7,           32'd0,          5'd9,  4,  32'hFFFF_FFFF};
        vecs[4]  = '{INST_REM,  32'h8000_0000,   32'hFFFF_FFFF,  5'd10, 2,  32'h0};
        vecs[5]  = '{INST_DIV,  32'h8000_0000,   32'hFFFF_FFFF,  5'd11, 3,  32'h8000_0000};
        vecs[6]  = '{INST_REM,  32'hFFFF_FFF9,   32'd2,          5'd1,  5,  32'hFFFF_FFFF};
        vecs[7]  = '{INST_DIV,  32'hFFFF_FFF9,   32'd2,          5'd2,  1,  32'hFFFF_FFFD};
        vecs[8]  = '{INST_REMU, 32'd5,           32'd0,          5'd31, 2,  32'd5};
        vecs[9]  = '{INST_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,  5'd4,  2,  32'h0};
        vecs[10] = '{INST_DIVU, 32'd1000,        32'd10,         5'd6,  40, 32'd100};

        rst = 1'b0; req_i = 1'b0; flush_i = 1'b0; op_i = '0;
        dividend_i = '0; divisor_i = '0; rd_i = '0;
        div_ready_i = 1'b0; div_result_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_start", 32'(div_start_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        rst = 1'b1;
        tick();

        // Vector table, issued back to back
        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].rd, vecs[i].lat, vecs[i].exp);
        idle(2);

        // Ready outside RUN is ignored
        spurious_rdy = 1;
        repeat (3) begin
            tick();
            chk("spurious_we", 32'(we_o), 32'd0);
            chk("spurious_start", 32'(div_start_o), 32'd0);
        end
        spurious_rdy = 0;

        // Flush in IDLE blocks acceptance
        req_i = 1'b1; flush_i = 1'b1; op_i = INST_DIV; dividend_i = 32'd9; divisor_i = 32'd3;
        #1;
        chk("idle_flush_stall", 32'(stall_o), 32'd0);
        tick();
        chk("idle_flush_start", 32'(div_start_o), 32'd0);
        idle(1);

        flush_run("flush_run", 20, 5);
        flush_run("flush_vs_ready", 3, 3);

        // Watchdog abort, stickiness, and clear on next accepted request
        hold_ready = 1;
        req_i = 1'b1; op_i = INST_DIVU; dividend_i = 32'd100; divisor_i = 32'd3; rd_i = 5'd8;
        starts  = 0;
        we_seen = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (we_o) we_seen = 1;
            if (div_start_o) starts++;
            else if (n > 0) break;
        end
        req_i = 1'b0;
        #1;
        chk("wd_run_cycles", 32'(starts), 32'd40);
        chk("wd_timeout", 32'(timeout_o), 32'd1);
        chk("wd_no_we", 32'(we_seen), 32'd0);
        chk("wd_stall", 32'(stall_o), 32'd0);
        tick();
        chk("wd_sticky", 32'(timeout_o), 32'd1);
        chk("wd_no_restart", 32'(div_start_o), 32'd0);
        hold_ready = 0;
        do_op("after_wd", INST_REMU, 32'd100, 32'd7, 5'd13, 2, 32'd2);
        idle(1);

        // Asynchronous reset mid-RUN
        div_lat = 30;
        req_i = 1'b1; op_i = INST_DIV; dividend_i = 32'd50; divisor_i = 32'd5; rd_i = 5'd14;
        repeat (5) tick();
        chk("pre_rst_start", 32'(div_start_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_start", 32'(div_start_o), 32'd0);
        chk("mid_rst_a", div_dividend_o, 32'd0);
        chk("mid_rst_b", div_divisor_o, 32'd0);
        chk("mid_rst_op", 32'(div_op_o), 32'd0);
        chk("mid_rst_rd", 32'(div_reg_waddr_o), 32'd0);
        chk("mid_rst_we", 32'(we_o), 32'd0);
        chk("mid_rst_wdata", wdata_o, 32'd0);
        chk("mid_rst_waddr", 32'(waddr_o), 32'd0);
        req_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        do_op("after_rst", INST_DIV, 32'd50, 32'd5, 5'd14, 3, 32'd10);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = INST_DIV | 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(1, 31)),
                  int'($urandom_range(1, 6)), ref_div(rop, ra, rb));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
